id_ex_mem_backend: RTL and testbench
====================================

// Module: id_ex_mem_backend
// PURPOSE
//  Middle of the 5-stage 16-bit pipeline. Holds the ID/EX register, the EX/MEM register and the word-addressed data memory.
//  Decode-stage values are registered into EX. EX results are registered into MEM, which drives the data memory.
//  Sits between the decoder/register file and the external MEM/WB register. Flush and stall come from the branch and hazard units.
// PARAMETERS
//  DM_AW  16  data memory address width; depth 2**DM_AW words of 16 bits.
// PORTS
//  clk                       in   1   clock, all registers on posedge
//  rst_n                     in   1   one clock; reset is asynchronous and active-low
//  flush                     in   1   sync clear of ID/EX and EX/MEM (taken branch in MEM)
//  stall                     in   1   sync clear of ID/EX only (load-use bubble)
//  im_instr_IN/_OUT          in/out 16 instruction
//  pc_plus1_IN/_OUT          in/out 16 PC+1
//  rf_r1_IN/_OUT             in/out 16 register-file read port 0 data
//  rf_r2_IN/_OUT             in/out 16 register-file read port 1 data
//  sext4/9/12_IN/_OUT        in/out 16 each, sign-extended immediates
//  rs_IN/_OUT, rt_IN/_OUT    in/out 4  source register numbers (for forwarding)
//  br_info_IN/_OUT           in/out 4  {take_branch, cond[2:0]}
//  id ctrl _IN/_OUT          in/out 1 each: rf_we, alu_alt_src, dm_rd_en, dm_wr_en, mem_to_reg,
//                                   op_jal, op_jr, take_branch, flag_wr_en, rf_hlt
//  alu_out_EX_IN/_OUT        in/out 16 ALU result / DM address
//  wrt_data_EX_IN/_OUT       in/out 16 store data (post-forwarding)
//  pp1_EX_IN/_OUT            in/out 16 PC+1 for JAL link
//  alt_pc_EX_IN/_OUT         in/out 16 branch/jump target
//  wr_reg_EX_IN/_OUT         in/out 4  destination register
//  br_info_EX_IN/_OUT        in/out 4  branch info
//  ex ctrl _EX_IN/_EX_OUT    in/out 1 each: dm_rd_en, dm_wr_en, mem_to_reg, rf_we, op_jal, op_jr, rf_hlt
//  dm_rd_data                out  16 data memory read data
// BEHAVIOUR
//  - rst_n low (async): every _OUT register is 0 immediately. dm_rd_data is 0 because the read enable is 0.
//    Memory contents are not cleared.
//  - ID/EX update at posedge, priority: flush > stall > load. Flush or stall loads all-zero, a NOP bubble.
//    An all-zero bubble means rf_we=0, dm_*=0, rf_hlt=0, flag_wr_en=0 and take_branch=0.
//  - EX/MEM update at posedge, priority: flush > load. Stall does not affect EX/MEM.
//  - Latency: exactly 1 cycle per register. No enable other than the above. There is no handshake.
//  - Flush and stall are synchronous. They are independent of rst_n. Simultaneous flush+stall equals flush.
//  - DM read: combinational. dm_rd_data = mem[alu_out_EX_OUT[DM_AW-1:0]] when dm_rd_en_EX_OUT=1, else 16'h0000.
//  - DM write: at posedge when dm_wr_en_EX_OUT=1, mem[addr] <= wrt_data_EX_OUT.
//  - DM read-during-write to the same address returns the old data. The new data is visible the next cycle.
//  - If both re and we are set, the write still occurs and the read returns the old word.
//  - Address bits above DM_AW are ignored, so addresses wrap modulo the depth.
//  - The write uses the registered EX/MEM values. A flush at the same edge does not cancel that write.
//  - Memory powers up as all zeros. Optional $readmemh from "dm.hex" is allowed in simulation only.
// STRUCTURE
//  - Shared package cpu_pkg: NOP_INSTR=16'h0000 and BR_INFO_W=4.
//  - One sub-module dm_mem: memory array, combinational read, posedge write.
//  - The two pipeline registers are always_ff blocks inside this module.
// TESTING
//  - Reset: set all _IN fields to 16'hFFFF/1, hold rst_n=0 -> every _OUT=0.
//    Release rst_n, then one clk -> ID/EX _OUT fields equal their _IN values.
//  - Stall: load instr=16'h8123 with rf_we=1, then stall=1 for one edge.
//    -> ID/EX _OUT fields all 0, while EX/MEM captures its inputs unchanged.
//  - Flush: flush=1 for one edge with nonzero inputs -> both ID/EX and EX/MEM are all 0 on the next cycle.
//  - DM store/load: write 16'hBEEF to addr 16'h0010, then read addr 0x10 -> dm_rd_data=16'hBEEF.
//    Read 0x11 -> 0. re=0 -> 0.
//  - Read-during-write: mem[5]=16'h1111, then write 16'h2222 to addr 5 with re=1.
//    -> the same cycle reads 1111, the next cycle reads 2222.
//  - Wrap: DM_AW=8, write to 16'h0103 -> a read of 16'h0003 returns the same data.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the 16-bit core.
package cpu_pkg;

  localparam int unsigned XLEN      = 16;
  localparam int unsigned REG_W     = 4;
  localparam int unsigned BR_INFO_W = 4;

  localparam logic [XLEN-1:0] NOP_INSTR = 16'h0000;

  // ID/EX payload: decode-stage values handed to execute.
  typedef struct packed {
    logic [XLEN-1:0]      instr;
    logic [XLEN-1:0]      pc_plus1;
    logic [XLEN-1:0]      rf_r1;
    logic [XLEN-1:0]      rf_r2;
    logic [XLEN-1:0]      sext4;
    logic [XLEN-1:0]      sext9;
    logic [XLEN-1:0]      sext12;
    logic [REG_W-1:0]     rs;
    logic [REG_W-1:0]     rt;
    logic [BR_INFO_W-1:0] br_info;
    logic                 rf_we;
    logic                 alu_alt_src;
    logic                 dm_rd_en;
    logic                 dm_wr_en;
    logic                 mem_to_reg;
    logic                 op_jal;
    logic                 op_jr;
    logic                 take_branch;
    logic                 flag_wr_en;
    logic                 rf_hlt;
  } id_ex_t;

  // EX/MEM payload: execute results that drive the data memory.
  typedef struct packed {
    logic [XLEN-1:0]      alu_out;
    logic [XLEN-1:0]      wrt_data;
    logic [XLEN-1:0]      pp1;
    logic [XLEN-1:0]      alt_pc;
    logic [REG_W-1:0]     wr_reg;
    logic [BR_INFO_W-1:0] br_info;
    logic                 dm_rd_en;
    logic                 dm_wr_en;
    logic                 mem_to_reg;
    logic                 rf_we;
    logic                 op_jal;
    logic                 op_jr;
    logic                 rf_hlt;
  } ex_mem_t;

  // Bubbles are all-zero; the instruction field carries the NOP encoding.
  localparam id_ex_t  ID_EX_BUBBLE  = '{instr: NOP_INSTR, default: '0};
  localparam ex_mem_t EX_MEM_BUBBLE = '{default: '0};

endpackage

// File: rtl/dm_mem.sv
// Word-addressed data memory: combinational gated read, posedge write.
module dm_mem
  import cpu_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic            clk,
  input  logic            re,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [XLEN-1:0] mem [DEPTH];

  // Write on the edge; a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read data is forced to zero when the read enable is low.
  always_comb begin
    rdata = '0;
    if (re) rdata = mem[addr];
  end

endmodule

// File: rtl/id_ex_mem_backend.sv
// ID/EX and EX/MEM pipeline registers plus the data memory.
module id_ex_mem_backend
  import cpu_pkg::*;
#(
  parameter int unsigned DM_AW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 stall,
  // decode-stage inputs
  input  logic [XLEN-1:0]      im_instr_IN,
  input  logic [XLEN-1:0]      pc_plus1_IN,
  input  logic [XLEN-1:0]      rf_r1_IN,
  input  logic [XLEN-1:0]      rf_r2_IN,
  input  logic [XLEN-1:0]      sext4_IN,
  input  logic [XLEN-1:0]      sext9_IN,
  input  logic [XLEN-1:0]      sext12_IN,
  input  logic [REG_W-1:0]     rs_IN,
  input  logic [REG_W-1:0]     rt_IN,
  input  logic [BR_INFO_W-1:0] br_info_IN,
  input  logic                 rf_we_IN,
  input  logic                 alu_alt_src_IN,
  input  logic                 dm_rd_en_IN,
  input  logic                 dm_wr_en_IN,
  input  logic                 mem_to_reg_IN,
  input  logic                 op_jal_IN,
  input  logic                 op_jr_IN,
  input  logic                 take_branch_IN,
  input  logic                 flag_wr_en_IN,
  input  logic                 rf_hlt_IN,
  // ID/EX outputs
  output logic [XLEN-1:0]      im_instr_OUT,
  output logic [XLEN-1:0]      pc_plus1_OUT,
  output logic [XLEN-1:0]      rf_r1_OUT,
  output logic [XLEN-1:0]      rf_r2_OUT,
  output logic [XLEN-1:0]      sext4_OUT,
  output logic [XLEN-1:0]      sext9_OUT,
  output logic [XLEN-1:0]      sext12_OUT,
  output logic [REG_W-1:0]     rs_OUT,
  output logic [REG_W-1:0]     rt_OUT,
  output logic [BR_INFO_W-1:0] br_info_OUT,
  output logic                 rf_we_OUT,
  output logic                 alu_alt_src_OUT,
  output logic                 dm_rd_en_OUT,
  output logic                 dm_wr_en_OUT,
  output logic                 mem_to_reg_OUT,
  output logic                 op_jal_OUT,
  output logic                 op_jr_OUT,
  output logic                 take_branch_OUT,
  output logic                 flag_wr_en_OUT,
  output logic                 rf_hlt_OUT,
  // execute-stage inputs
  input  logic [XLEN-1:0]      alu_out_EX_IN,
  input  logic [XLEN-1:0]      wrt_data_EX_IN,
  input  logic [XLEN-1:0]      pp1_EX_IN,
  input  logic [XLEN-1:0]      alt_pc_EX_IN,
  input  logic [REG_W-1:0]     wr_reg_EX_IN,
  input  logic [BR_INFO_W-1:0] br_info_EX_IN,
  input  logic                 dm_rd_en_EX_IN,
  input  logic                 dm_wr_en_EX_IN,
  input  logic                 mem_to_reg_EX_IN,
  input  logic                 rf_we_EX_IN,
  input  logic                 op_jal_EX_IN,
  input  logic                 op_jr_EX_IN,
  input  logic                 rf_hlt_EX_IN,
  // EX/MEM outputs
  output logic [XLEN-1:0]      alu_out_EX_OUT,
  output logic [XLEN-1:0]      wrt_data_EX_OUT,
  output logic [XLEN-1:0]      pp1_EX_OUT,
  output logic [XLEN-1:0]      alt_pc_EX_OUT,
  output logic [REG_W-1:0]     wr_reg_EX_OUT,
  output logic [BR_INFO_W-1:0] br_info_EX_OUT,
  output logic                 dm_rd_en_EX_OUT,
  output logic                 dm_wr_en_EX_OUT,
  output logic                 mem_to_reg_EX_OUT,
  output logic                 rf_we_EX_OUT,
  output logic                 op_jal_EX_OUT,
  output logic                 op_jr_EX_OUT,
  output logic                 rf_hlt_EX_OUT,
  // data memory
  output logic [XLEN-1:0]      dm_rd_data
);

  id_ex_t  id_ex_d,  id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;

  // Gather decode-stage inputs into the ID/EX payload.
  always_comb begin
    id_ex_d = '{
      instr:       im_instr_IN,
      pc_plus1:    pc_plus1_IN,
      rf_r1:       rf_r1_IN,
      rf_r2:       rf_r2_IN,
      sext4:       sext4_IN,
      sext9:       sext9_IN,
      sext12:      sext12_IN,
      rs:          rs_IN,
      rt:          rt_IN,
      br_info:     br_info_IN,
      rf_we:       rf_we_IN,
      alu_alt_src: alu_alt_src_IN,
      dm_rd_en:    dm_rd_en_IN,
      dm_wr_en:    dm_wr_en_IN,
      mem_to_reg:  mem_to_reg_IN,
      op_jal:      op_jal_IN,
      op_jr:       op_jr_IN,
      take_branch: take_branch_IN,
      flag_wr_en:  flag_wr_en_IN,
      rf_hlt:      rf_hlt_IN
    };
  end

  // Gather execute-stage inputs into the EX/MEM payload.
  always_comb begin
    ex_mem_d = '{
      alu_out:    alu_out_EX_IN,
      wrt_data:   wrt_data_EX_IN,
      pp1:        pp1_EX_IN,
      alt_pc:     alt_pc_EX_IN,
      wr_reg:     wr_reg_EX_IN,
      br_info:    br_info_EX_IN,
      dm_rd_en:   dm_rd_en_EX_IN,
      dm_wr_en:   dm_wr_en_EX_IN,
      mem_to_reg: mem_to_reg_EX_IN,
      rf_we:      rf_we_EX_IN,
      op_jal:     op_jal_EX_IN,
      op_jr:      op_jr_EX_IN,
      rf_hlt:     rf_hlt_EX_IN
    };
  end

  // ID/EX register: flush or stall inserts a bubble, flush taking priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              id_ex_q <= '0;
    else if (flush || stall) id_ex_q <= ID_EX_BUBBLE;
    else                     id_ex_q <= id_ex_d;
  end

  // EX/MEM register: only flush clears it; a load-use stall lets EX drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ex_mem_q <= '0;
    else if (flush) ex_mem_q <= EX_MEM_BUBBLE;
    else            ex_mem_q <= ex_mem_d;
  end

  assign im_instr_OUT    = id_ex_q.instr;
  assign pc_plus1_OUT    = id_ex_q.pc_plus1;
  assign rf_r1_OUT       = id_ex_q.rf_r1;
  assign rf_r2_OUT       = id_ex_q.rf_r2;
  assign sext4_OUT       = id_ex_q.sext4;
  assign sext9_OUT       = id_ex_q.sext9;
  assign sext12_OUT      = id_ex_q.sext12;
  assign rs_OUT          = id_ex_q.rs;
  assign rt_OUT          = id_ex_q.rt;
  assign br_info_OUT     = id_ex_q.br_info;
  assign rf_we_OUT       = id_ex_q.rf_we;
  assign alu_alt_src_OUT = id_ex_q.alu_alt_src;
  assign dm_rd_en_OUT    = id_ex_q.dm_rd_en;
  assign dm_wr_en_OUT    = id_ex_q.dm_wr_en;
  assign mem_to_reg_OUT  = id_ex_q.mem_to_reg;
  assign op_jal_OUT      = id_ex_q.op_jal;
  assign op_jr_OUT       = id_ex_q.op_jr;
  assign take_branch_OUT = id_ex_q.take_branch;
  assign flag_wr_en_OUT  = id_ex_q.flag_wr_en;
  assign rf_hlt_OUT      = id_ex_q.rf_hlt;

  assign alu_out_EX_OUT    = ex_mem_q.alu_out;
  assign wrt_data_EX_OUT   = ex_mem_q.wrt_data;
  assign pp1_EX_OUT        = ex_mem_q.pp1;
  assign alt_pc_EX_OUT     = ex_mem_q.alt_pc;
  assign wr_reg_EX_OUT     = ex_mem_q.wr_reg;
  assign br_info_EX_OUT    = ex_mem_q.br_info;
  assign dm_rd_en_EX_OUT   = ex_mem_q.dm_rd_en;
  assign dm_wr_en_EX_OUT   = ex_mem_q.dm_wr_en;
  assign mem_to_reg_EX_OUT = ex_mem_q.mem_to_reg;
  assign rf_we_EX_OUT      = ex_mem_q.rf_we;
  assign op_jal_EX_OUT     = ex_mem_q.op_jal;
  assign op_jr_EX_OUT      = ex_mem_q.op_jr;
  assign rf_hlt_EX_OUT     = ex_mem_q.rf_hlt;

  // Data memory addressed by the low DM_AW bits of the registered ALU result.
  dm_mem #(.AW(DM_AW)) u_dm_mem (
    .clk   (clk),
    .re    (ex_mem_q.dm_rd_en),
    .we    (ex_mem_q.dm_wr_en),
    .addr  (ex_mem_q.alu_out[DM_AW-1:0]),
    .wdata (ex_mem_q.wrt_data),
    .rdata (dm_rd_data)
  );

endmodule

// File: tb/tb_id_ex_mem_backend.sv
// Directed bench for the ID/EX, EX/MEM registers and data memory.
module tb_id_ex_mem_backend;

  logic clk = 1'b0;
  logic rst_n, flush, stall;

  logic [15:0] im_instr_IN, pc_plus1_IN, rf_r1_IN, rf_r2_IN, sext4_IN, sext9_IN, sext12_IN;
  logic [3:0]  rs_IN, rt_IN, br_info_IN;
  logic rf_we_IN, alu_alt_src_IN, dm_rd_en_IN, dm_wr_en_IN, mem_to_reg_IN;
  logic op_jal_IN, op_jr_IN, take_branch_IN, flag_wr_en_IN, rf_hlt_IN;
  logic [15:0] im_instr_OUT, pc_plus1_OUT, rf_r1_OUT, rf_r2_OUT, sext4_OUT, sext9_OUT, sext12_OUT;
  logic [3:0]  rs_OUT, rt_OUT, br_info_OUT;
  logic rf_we_OUT, alu_alt_src_OUT, dm_rd_en_OUT, dm_wr_en_OUT, mem_to_reg_OUT;
  logic op_jal_OUT, op_jr_OUT, take_branch_OUT, flag_wr_en_OUT, rf_hlt_OUT;

  logic [15:0] alu_out_EX_IN, wrt_data_EX_IN, pp1_EX_IN, alt_pc_EX_IN;
  logic [3:0]  wr_reg_EX_IN, br_info_EX_IN;
  logic dm_rd_en_EX_IN, dm_wr_en_EX_IN, mem_to_reg_EX_IN, rf_we_EX_IN;
  logic op_jal_EX_IN, op_jr_EX_IN, rf_hlt_EX_IN;
  logic [15:0] alu_out_EX_OUT, wrt_data_EX_OUT, pp1_EX_OUT, alt_pc_EX_OUT;
  logic [3:0]  wr_reg_EX_OUT, br_info_EX_OUT;
  logic dm_rd_en_EX_OUT, dm_wr_en_EX_OUT, mem_to_reg_EX_OUT, rf_we_EX_OUT;
  logic op_jal_EX_OUT, op_jr_EX_OUT, rf_hlt_EX_OUT;
  logic [15:0] dm_rd_data;

  int checks = 0;
  int errors = 0;

  logic [133:0] id_drv;
  logic [78:0]  ex_drv;

  wire logic [133:0] id_out_bus = {im_instr_OUT, pc_plus1_OUT, rf_r1_OUT, rf_r2_OUT,
    sext4_OUT, sext9_OUT, sext12_OUT, rs_OUT, rt_OUT, br_info_OUT,
    rf_we_OUT, alu_alt_src_OUT, dm_rd_en_OUT, dm_wr_en_OUT, mem_to_reg_OUT,
    op_jal_OUT, op_jr_OUT, take_branch_OUT, flag_wr_en_OUT, rf_hlt_OUT};
  wire logic [78:0] ex_out_bus = {alu_out_EX_OUT, wrt_data_EX_OUT, pp1_EX_OUT, alt_pc_EX_OUT,
    wr_reg_EX_OUT, br_info_EX_OUT, dm_rd_en_EX_OUT, dm_wr_en_EX_OUT, mem_to_reg_EX_OUT,
    rf_we_EX_OUT, op_jal_EX_OUT, op_jr_EX_OUT, rf_hlt_EX_OUT};

  id_ex_mem_backend #(.DM_AW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .im_instr_IN(im_instr_IN), .pc_plus1_IN(pc_plus1_IN), .rf_r1_IN(rf_r1_IN), .rf_r2_IN(rf_r2_IN),
    .sext4_IN(sext4_IN), .sext9_IN(sext9_IN), .sext12_IN(sext12_IN),
    .rs_IN(rs_IN), .rt_IN(rt_IN), .br_info_IN(br_info_IN),
    .rf_we_IN(rf_we_IN), .alu_alt_src_IN(alu_alt_src_IN), .dm_rd_en_IN(dm_rd_en_IN),
    .dm_wr_en_IN(dm_wr_en_IN), .mem_to_reg_IN(mem_to_reg_IN), .op_jal_IN(op_jal_IN),
    .op_jr_IN(op_jr_IN), .take_branch_IN(take_branch_IN), .flag_wr_en_IN(flag_wr_en_IN),
    .rf_hlt_IN(rf_hlt_IN),
    .im_instr_OUT(im_instr_OUT), .pc_plus1_OUT(pc_plus1_OUT), .rf_r1_OUT(rf_r1_OUT),
    .rf_r2_OUT(rf_r2_OUT), .sext4_OUT(sext4_OUT), .sext9_OUT(sext9_OUT), .sext12_OUT(sext12_OUT),
    .rs_OUT(rs_OUT), .rt_OUT(rt_OUT), .br_info_OUT(br_info_OUT),
    .rf_we_OUT(rf_we_OUT), .alu_alt_src_OUT(alu_alt_src_OUT), .dm_rd_en_OUT(dm_rd_en_OUT),
    .dm_wr_en_OUT(dm_wr_en_OUT), .mem_to_reg_OUT(mem_to_reg_OUT), .op_jal_OUT(op_jal_OUT),
    .op_jr_OUT(op_jr_OUT), .take_branch_OUT(take_branch_OUT), .flag_wr_en_OUT(flag_wr_en_OUT),
    .rf_hlt_OUT(rf_hlt_OUT),
    .alu_out_EX_IN(alu_out_EX_IN), .wrt_data_EX_IN(wrt_data_EX_IN), .pp1_EX_IN(pp1_EX_IN),
    .alt_pc_EX_IN(alt_pc_EX_IN), .wr_reg_EX_IN(wr_reg_EX_IN), .br_info_EX_IN(br_info_EX_IN),
    .dm_rd_en_EX_IN(dm_rd_en_EX_IN), .dm_wr_en_EX_IN(dm_wr_en_EX_IN),
    .mem_to_reg_EX_IN(mem_to_reg_EX_IN), .rf_we_EX_IN(rf_we_EX_IN), .op_jal_EX_IN(op_jal_EX_IN),
    .op_jr_EX_IN(op_jr_EX_IN), .rf_hlt_EX_IN(rf_hlt_EX_IN),
    .alu_out_EX_OUT(alu_out_EX_OUT), .wrt_data_EX_OUT(wrt_data_EX_OUT), .pp1_EX_OUT(pp1_EX_OUT),
    .alt_pc_EX_OUT(alt_pc_EX_OUT), .wr_reg_EX_OUT(wr_reg_EX_OUT), .br_info_EX_OUT(br_info_EX_OUT),
    .dm_rd_en_EX_OUT(dm_rd_en_EX_OUT), .dm_wr_en_EX_OUT(dm_wr_en_EX_OUT),
    .mem_to_reg_EX_OUT(mem_to_reg_EX_OUT), .rf_we_EX_OUT(rf_we_EX_OUT),
    .op_jal_EX_OUT(op_jal_EX_OUT), .op_jr_EX_OUT(op_jr_EX_OUT), .rf_hlt_EX_OUT(rf_hlt_EX_OUT),
    .dm_rd_data(dm_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] r1,
                        input logic [15:0] r2, input logic [15:0] s4, input logic [15:0] s9,
                        input logic [15:0] s12, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] br, input logic [9:0] ctrl);
    im_instr_IN = instr; pc_plus1_IN = pc; rf_r1_IN = r1; rf_r2_IN = r2;
    sext4_IN = s4; sext9_IN = s9; sext12_IN = s12; rs_IN = rs; rt_IN = rt; br_info_IN = br;
    {rf_we_IN, alu_alt_src_IN, dm_rd_en_IN, dm_wr_en_IN, mem_to_reg_IN,
     op_jal_IN, op_jr_IN, take_branch_IN, flag_wr_en_IN, rf_hlt_IN} = ctrl;
    id_drv = {instr, pc, r1, r2, s4, s9, s12, rs, rt, br, ctrl};
  endtask

  // ctrl bits: {dm_rd_en, dm_wr_en, mem_to_reg, rf_we, op_jal, op_jr, rf_hlt}
  task automatic set_ex(input logic [15:0] alu, input logic [15:0] wd, input logic [15:0] pp1,
                        input logic [15:0] alt, input logic [3:0] wr, input logic [3:0] br,
                        input logic [6:0] ctrl);
    alu_out_EX_IN = alu; wrt_data_EX_IN = wd; pp1_EX_IN = pp1; alt_pc_EX_IN = alt;
    wr_reg_EX_IN = wr; br_info_EX_IN = br;
    {dm_rd_en_EX_IN, dm_wr_en_EX_IN, mem_to_reg_EX_IN, rf_we_EX_IN,
     op_jal_EX_IN, op_jr_EX_IN, rf_hlt_EX_IN} = ctrl;
    ex_drv = {alu, wd, pp1, alt, wr, br, ctrl};
  endtask

  initial begin
    // reset with every input at all-ones
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    set_id(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
           4'hF, 4'hF, 4'hF, 10'h3FF);
    set_ex(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 7'h7F);
    #1;
    chk("rst_async_id", 134'(id_out_bus), 134'(0));
    chk("rst_async_ex", 134'(ex_out_bus), 134'(0));
    chk("rst_dm_rd", 134'(dm_rd_data), 134'(0));
    step(); step();
    chk("rst_held_id", 134'(id_out_bus), 134'(0));
    chk("rst_held_ex", 134'(ex_out_bus), 134'(0));

    #3 rst_n = 1'b1;
    step();
    chk("load_id_ones", 134'(id_out_bus), 134'(id_drv));
    chk("load_ex_ones", 134'(ex_out_bus), 134'(ex_drv));

    // stall: ID/EX bubbles, EX/MEM keeps loading
    set_id(16'h8123, 16'h0001, 16'h1111, 16'h2222, 16'h0004, 16'hFF09, 16'h0012,
           4'h2, 4'h3, 4'h0, 10'b10_0000_0000);
    set_ex(16'h1234, 16'h5678, 16'h0042, 16'h0099, 4'h3, 4'hA, 7'b0011000);
    step();
    chk("load_instr", 134'(im_instr_OUT), 134'(16'h8123));
    chk("load_rf_we", 134'(rf_we_OUT), 134'(1'b1));
    chk("load_id", 134'(id_out_bus), 134'(id_drv));
    chk("load_ex", 134'(ex_out_bus), 134'(ex_drv));
    stall = 1'b1;
    set_ex(16'h0ABC, 16'h0DEF, 16'h0043, 16'h00A0, 4'h5, 4'h3, 7'b0001101);
    step();
    chk("stall_id_zero", 134'(id_out_bus), 134'(0));
    chk("stall_ex_loads", 134'(ex_out_bus), 134'(ex_drv));
    stall = 1'b0;
    step();
    chk("unstall_id", 134'(id_out_bus), 134'(id_drv));

    // flush clears both registers
    flush = 1'b1;
    step();
    chk("flush_id_zero", 134'(id_out_bus), 134'(0));
    chk("flush_ex_zero", 134'(ex_out_bus), 134'(0));
    flush = 1'b0;
    step();
    chk("post_flush_id", 134'(id_out_bus), 134'(id_drv));
    flush = 1'b1; stall = 1'b1;
    step();
    chk("flush_stall_id", 134'(id_out_bus), 134'(0));
    chk("flush_stall_ex", 134'(ex_out_bus), 134'(0));
    flush = 1'b0; stall = 1'b0;

    // store BEEF to 0x10, store 0 to 0x11, then read both and read with re=0
    set_id(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 10'h0);
    set_ex(16'h0010, 16'hBEEF, 16'h0, 16'h0, 4'h0, 4'h0, 7'b0100000);
    step();
    set_ex(16'h0011, 16'h0000, 16'h0, 16'h0, 4'h0, 4'h0, 7'b0100000);
    step();
    set_ex(16'h0010, 16'h0000, 16'h0, 16'h0, 4'h0, 4'h0, 7'b1000000);
    step();
    chk("dm_load_10", 134'(dm_rd_data), 134'(16'hBEEF));
    set_ex(16'h0011, 16'h0000, 16'h0, 16'h0, 4'h0, 4'h0, 7'b1000000);
    step();
    chk("dm_load_11", 134'(dm_rd_data), 134'(16'h0000));
    set_ex(16'h0010, 16'h0000, 16'h0, 16'h0, 4'h0, 4'h0, 7'b0000000);
    step();
    chk("dm_re0", 134'(dm_rd_data), 134'(16'h0000));

    // read-during-write returns old data, new data next cycle
    set_ex(16'h0005, 16'h1111, 16'h0, 16'h0, 4'h0, 4'h0, 7'b0100000);
    step();
    set_ex(16'h0005, 16'h2222, 16'h0, 16'h0, 4'h0, 4'h0, 7'b1100000);
    step();
    chk("rdw_old", 134'(dm_rd_data), 134'(16'h1111));
    set_ex(16'h0005, 16'h0000, 16'h0, 16'h0, 4'h0, 4'h0, 7'b1000000);
    step();
    chk("rdw_new", 134'(dm_rd_data), 134'(16'h2222));

    // a flush on the same edge does not cancel the pending store
    set_ex(16'h0020, 16'h7777, 16'h0, 16'h0, 4'h0, 4'h0, 7'b0100000);
    step();
    flush = 1'b1;
    set_ex(16'h0020, 16'h0000, 16'h0, 16'h0, 4'h0, 4'h0, 7'b1000000);
    step();
    chk("flush_wr_ex_zero", 134'(ex_out_bus), 134'(0));
    chk("flush_wr_rd_zero", 134'(dm_rd_data), 134'(16'h0000));
    flush = 1'b0;
    step();
    chk("flush_wr_kept", 134'(dm_rd_data), 134'(16'h7777));

    // address wrap modulo 2**8
    set_ex(16'h0103, 16'hABCD, 16'h0, 16'h0, 4'h0, 4'h0, 7'b0100000);
    step();
    set_ex(16'h0003, 16'h0000, 16'h0, 16'h0, 4'h0, 4'h0, 7'b1000000);
    step();
    chk("wrap_0003", 134'(dm_rd_data), 134'(16'hABCD));
    set_ex(16'hFF03, 16'h0000, 16'h0, 16'h0, 4'h0, 4'h0, 7'b1000000);
    step();
    chk("wrap_ff03", 134'(dm_rd_data), 134'(16'hABCD));

    // async reset mid-run clears outputs without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ex", 134'(ex_out_bus), 134'(0));
    chk("rst_mid_dm", 134'(dm_rd_data), 134'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
